// File: rtl/time_setting_ctrl_pkg.sv
// Shared state/field codes, BCD limits and capture normalisation
// helpers for the time setting editor.
package time_setting_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_EDIT  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  localparam logic [1:0] F_HOUR = 2'b00;
  localparam logic [1:0] F_MIN  = 2'b01;
  localparam logic [1:0] F_SEC  = 2'b10;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_19 = 8'h19;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Valid BCD compares correctly as plain hex.
  function automatic logic [7:0] norm_ms(input logic [7:0] v);
    return (bcd_ok(v) && v <= BCD_59) ? v : BCD_00;
  endfunction

  // 12h folds 00 -> 12 and 13..23 -> h-12.
  // 20/21 need a nibble borrow, hence -18.
  function automatic logic [7:0] norm_hour(
    input logic [7:0] v,
    input logic       m12
  );
    logic [7:0] r;
    if (!bcd_ok(v) || v > BCD_23)
      r = m12 ? BCD_01 : BCD_00;
    else if (!m12)
      r = v;
    else if (v == BCD_00)
      r = BCD_12;
    else if (v <= BCD_12)
      r = v;
    else if (v <= BCD_19)
      r = v - 8'h12;
    else if (v == 8'h20 || v == 8'h21)
      r = v - 8'h18;
    else
      r = v - 8'h12;
    return r;
  endfunction

endpackage

// File: rtl/time_setting_ctrl_bcd_wrap_step.sv
// Combinational 8-bit BCD +/-1 with wrap between lo and hi.
// Ports: val (in), up (1=+1, 0=-1), lo/hi limits, res (out).
module time_setting_ctrl_bcd_wrap_step (
  input  logic [7:0] val,
  input  logic       up,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  output logic [7:0] res
);

  always_comb begin
    res = val;
    if (up) begin
      if (val == hi)
        res = lo;
      else if (val[3:0] == 4'd9)
        res = {val[7:4] + 4'd1, 4'd0};
      else
        res = val + 8'd1;
    end else begin
      if (val == lo)
        res = hi;
      else if (val[3:0] == 4'd0)
        res = {val[7:4] - 4'd1, 4'd9};
      else
        res = val - 8'd1;
    end
  end

endmodule

// File: rtl/time_setting_ctrl.sv
// Auto-repeat BCD time editor: load a slot, step h/m/s, write back.
// Ports: CLK/RST_N, buttons, in* capture, out* working time, wr_* port.
module time_setting_ctrl
  import time_setting_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int CNT_W         = 16,
  localparam int SLOT_W =
    (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              mode,
  input  logic [SLOT_W-1:0] slot_sel,
  input  logic              edit_start,
  input  logic              field_next,
  input  logic              inc,
  input  logic              dec,
  input  logic              commit,
  input  logic              cancel,
  input  logic [7:0]        inHour,
  input  logic [7:0]        inMinute,
  input  logic [7:0]        inSecond,
  output logic              editing,
  output logic [1:0]        field,
  output logic [7:0]        outHour,
  output logic [7:0]        outMinute,
  output logic [7:0]        outSecond,
  output logic              wr_valid,
  output logic [SLOT_W-1:0] wr_slot,
  input  logic              wr_ready
);

  localparam logic [CNT_W-1:0] DLY_LIM =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LIM =
    CNT_W'(REPEAT_PERIOD - 1);

  state_e           state;
  logic             inc_q;
  logic             dec_q;
  logic             rep;
  logic [CNT_W-1:0] cnt;

  logic       up_only;
  logic       dn_only;
  logic       hold;
  logic       press;
  logic       step;
  logic       fix;
  logic [7:0] hour_fix;
  logic [7:0] cur;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [7:0] nxt;

  assign up_only = inc & ~dec;
  assign dn_only = dec & ~inc;
  assign hold = (state == S_EDIT)
    & (up_only | dn_only);
  assign press = hold
    & ((up_only & ~inc_q) | (dn_only & ~dec_q));
  assign step = press
    | (hold & (cnt == (rep ? PER_LIM : DLY_LIM)));

  // A 24h hour left over after switching to 12h
  // is folded before any hour step is allowed.
  assign hour_fix = norm_hour(outHour, mode);
  assign fix = (hour_fix != outHour);

  always_comb begin
    cur = outHour;
    lo  = mode ? BCD_01 : BCD_00;
    hi  = mode ? BCD_12 : BCD_23;
    unique case (1'b1)
      field == F_MIN: begin
        cur = outMinute;
        lo  = BCD_00;
        hi  = BCD_59;
      end
      field == F_SEC: begin
        cur = outSecond;
        lo  = BCD_00;
        hi  = BCD_59;
      end
      default: ;
    endcase
  end

  time_setting_ctrl_bcd_wrap_step u_step (
    .val (cur),
    .up  (up_only),
    .lo  (lo),
    .hi  (hi),
    .res (nxt)
  );

  // First repeat after DELAY, later ones every PERIOD.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      cnt   <= '0;
      rep   <= 1'b0;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      if (!hold || press) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (step) begin
        cnt <= '0;
        rep <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      editing   <= 1'b0;
      field     <= F_HOUR;
      outHour   <= BCD_00;
      outMinute <= BCD_00;
      outSecond <= BCD_00;
      wr_valid  <= 1'b0;
      wr_slot   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (edit_start) begin
            state   <= S_LOAD;
            editing <= 1'b1;
            wr_slot <= slot_sel;
          end
        end
        S_LOAD: begin
          outHour   <= norm_hour(inHour, mode);
          outMinute <= norm_ms(inMinute);
          outSecond <= norm_ms(inSecond);
          field     <= F_HOUR;
          state     <= S_EDIT;
        end
        S_EDIT: begin
          if (fix)
            outHour <= hour_fix;
          else if (step && field == F_HOUR)
            outHour <= nxt;
          if (step && field == F_MIN)
            outMinute <= nxt;
          if (step && field == F_SEC)
            outSecond <= nxt;
          if (field_next)
            field <= (field == F_SEC) ?
              F_HOUR : field + 2'd1;
          if (cancel) begin
            state   <= S_IDLE;
            editing <= 1'b0;
          end else if (commit) begin
            state    <= S_WRITE;
            wr_valid <= 1'b1;
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            state    <= S_IDLE;
            editing  <= 1'b0;
            wr_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_setting_ctrl.sv
// Bench for time_setting_ctrl: directed scenarios plus random
// stimulus checked every cycle against a decimal behavioural model.
module tb_time_setting_ctrl;

  localparam int NS = 4;
  localparam int D  = 5;
  localparam int P  = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] slot_sel = 2'd0;
  logic       edit_start = 1'b0;
  logic       field_next = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       commit = 1'b0;
  logic       cancel = 1'b0;
  logic [7:0] inHour = 8'h00;
  logic [7:0] inMinute = 8'h00;
  logic [7:0] inSecond = 8'h00;
  logic       wr_ready = 1'b0;
  logic       editing;
  logic [1:0] field;
  logic [7:0] outHour;
  logic [7:0] outMinute;
  logic [7:0] outSecond;
  logic       wr_valid;
  logic [1:0] wr_slot;

  always #5 CLK = ~CLK;

  time_setting_ctrl #(
    .NUM_SLOTS(NS),
    .REPEAT_DELAY(D),
    .REPEAT_PERIOD(P),
    .CNT_W(8)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .mode(mode),
    .slot_sel(slot_sel),
    .edit_start(edit_start),
    .field_next(field_next),
    .inc(inc),
    .dec(dec),
    .commit(commit),
    .cancel(cancel),
    .inHour(inHour),
    .inMinute(inMinute),
    .inSecond(inSecond),
    .editing(editing),
    .field(field),
    .outHour(outHour),
    .outMinute(outMinute),
    .outSecond(outSecond),
    .wr_valid(wr_valid),
    .wr_slot(wr_slot),
    .wr_ready(wr_ready)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 load, 2 edit, 3 write; times kept as decimals.
  int m_st = 0;
  int m_h = 0;
  int m_m = 0;
  int m_s = 0;
  int m_f = 0;
  int m_slot = 0;
  int m_hold = 0;
  bit m_pi = 1'b0;
  bit m_pd = 1'b0;

  function automatic int bval(logic [7:0] x);
    int hi_n = int'(x[7:4]);
    int lo_n = int'(x[3:0]);
    if (hi_n > 9 || lo_n > 9) return -1;
    return hi_n * 10 + lo_n;
  endfunction

  function automatic logic [7:0] bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic int cap_ms(logic [7:0] x);
    int v = bval(x);
    return (v < 0 || v > 59) ? 0 : v;
  endfunction

  function automatic int cap_h(logic [7:0] x, bit m12);
    int v = bval(x);
    if (!m12) return (v < 0 || v > 23) ? 0 : v;
    if (v < 0 || v > 23) return 1;
    if (v == 0) return 12;
    if (v > 12) return v - 12;
    return v;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_st = 0; m_h = 0; m_m = 0; m_s = 0;
      m_f = 0; m_slot = 0; m_hold = 0;
      m_pi = 1'b0; m_pd = 1'b0;
    end else begin
      bit uo;
      bit dn;
      bit stp;
      int d;
      uo = inc && !dec;
      dn = dec && !inc;
      stp = 1'b0;
      if (m_st == 2 && (uo || dn)) begin
        if (uo ? !m_pi : !m_pd) begin
          m_hold = 1;
          stp = 1'b1;
        end else begin
          m_hold = (m_hold == 0) ? 2 : m_hold + 1;
          stp = (m_hold > D) && ((m_hold - 1 - D) % P == 0);
        end
      end else begin
        m_hold = 0;
      end
      d = uo ? 1 : -1;
      m_pi = inc;
      m_pd = dec;
      case (m_st)
        0: if (edit_start) begin
          m_st = 1;
          m_slot = int'(slot_sel);
        end
        1: begin
          m_h = cap_h(inHour, mode);
          m_m = cap_ms(inMinute);
          m_s = cap_ms(inSecond);
          m_f = 0;
          m_st = 2;
        end
        2: begin
          if (mode && (m_h == 0 || m_h > 12))
            m_h = (m_h == 0) ? 12 : m_h - 12;
          else if (stp && m_f == 0)
            m_h = mode ? ((m_h - 1 + d + 12) % 12) + 1
                       : (m_h + d + 24) % 24;
          if (stp && m_f == 1) m_m = (m_m + d + 60) % 60;
          if (stp && m_f == 2) m_s = (m_s + d + 60) % 60;
          if (field_next) m_f = (m_f + 1) % 3;
          if (cancel) m_st = 0;
          else if (commit) m_st = 3;
        end
        default: if (wr_ready) m_st = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    logic [29:0] act;
    logic [29:0] exp_v;
    act = {editing, field, outHour, outMinute, outSecond,
           wr_valid, wr_slot};
    exp_v = {m_st != 0, 2'(m_f), bcd(m_h), bcd(m_m), bcd(m_s),
             m_st == 3, 2'(m_slot)};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t {ed,fld,h,m,s,wv,slot} got %h expected %h",
               $time, act, exp_v);
    end
  end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic start_edit(logic [1:0] sl, logic [7:0] h,
                            logic [7:0] m, logic [7:0] s);
    slot_sel = sl;
    inHour = h;
    inMinute = m;
    inSecond = s;
    edit_start = 1'b1;
    tick(1);
    edit_start = 1'b0;
    tick(1);
  endtask

  bit t5_on = 1'b0;
  bit wv_seen = 1'b0;
  always @(posedge CLK)
    if (t5_on && wr_valid) wv_seen = 1'b1;

  initial begin
    tick(3);
    chk("rst_editing", 32'(editing), 0);
    chk("rst_field", 32'(field), 0);
    chk("rst_hour", 32'(outHour), 0);
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_slot", 32'(wr_slot), 0);
    RST_N = 1'b1;
    tick(2);

    // T1: 24h hour 23 wraps to 00, write to slot 2.
    start_edit(2'd2, 8'h23, 8'h45, 8'h07);
    chk("t1_load_hour", 32'(outHour), 32'h23);
    chk("t1_editing", 32'(editing), 1);
    inc = 1'b1;
    tick(1);
    inc = 1'b0;
    chk("t1_hour_wrap", 32'(outHour), 32'h00);
    chk("t1_min_kept", 32'(outMinute), 32'h45);
    chk("t1_field", 32'(field), 0);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    chk("t1_wr_valid", 32'(wr_valid), 1);
    chk("t1_wr_slot", 32'(wr_slot), 2);
    wr_ready = 1'b1;
    tick(1);
    wr_ready = 1'b0;
    chk("t1_idle_wv", 32'(wr_valid), 0);
    chk("t1_idle_ed", 32'(editing), 0);

    // T2: auto-repeat on minute 57.
    start_edit(2'd0, 8'h10, 8'h57, 8'h00);
    field_next = 1'b1;
    tick(1);
    field_next = 1'b0;
    chk("t2_field_min", 32'(field), 1);
    inc = 1'b1;
    tick(1);
    chk("t2_first", 32'(outMinute), 32'h58);
    tick(D - 1);
    chk("t2_before_rep", 32'(outMinute), 32'h58);
    tick(1);
    chk("t2_rep1", 32'(outMinute), 32'h59);
    tick(P);
    chk("t2_rep2_wrap", 32'(outMinute), 32'h00);
    tick(2);
    inc = 1'b0;
    tick(1);
    chk("t2_final", 32'(outMinute), 32'h00);
    chk("t2_hour_kept", 32'(outHour), 32'h10);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;

    // T3: 12h capture and wrap.
    mode = 1'b1;
    start_edit(2'd1, 8'h00, 8'h00, 8'h00);
    chk("t3_cap_00", 32'(outHour), 32'h12);
    dec = 1'b1;
    tick(1);
    dec = 1'b0;
    chk("t3_dec", 32'(outHour), 32'h11);
    inc = 1'b1;
    tick(1);
    inc = 1'b0;
    tick(1);
    inc = 1'b1;
    tick(1);
    inc = 1'b0;
    chk("t3_wrap_12_01", 32'(outHour), 32'h01);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    start_edit(2'd3, 8'h15, 8'h7A, 8'h60);
    chk("t3_cap_15", 32'(outHour), 32'h03);
    chk("t3_bad_min", 32'(outMinute), 32'h00);
    chk("t3_bad_sec", 32'(outSecond), 32'h00);
    mode = 1'b0;
    tick(1);
    chk("t3_to_24h", 32'(outHour), 32'h03);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;

    // T4: write held off by wr_ready; cancel ignored in WRITE.
    start_edit(2'd1, 8'h09, 8'h30, 8'h59);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_wv_wait", 32'(wr_valid), 1);
      chk("t4_data", {8'h0, outHour, outMinute, outSecond},
          32'h00093059);
      chk("t4_slot", 32'(wr_slot), 1);
      cancel = (i == 2);
      tick(1);
    end
    cancel = 1'b0;
    wr_ready = 1'b1;
    chk("t4_wv_last", 32'(wr_valid), 1);
    tick(1);
    wr_ready = 1'b0;
    chk("t4_done_wv", 32'(wr_valid), 0);
    chk("t4_done_ed", 32'(editing), 0);

    // T5: inc and dec together never step.
    start_edit(2'd2, 8'h07, 8'h08, 8'h09);
    t5_on = 1'b1;
    inc = 1'b1;
    dec = 1'b1;
    tick(1000);
    inc = 1'b0;
    dec = 1'b0;
    chk("t5_hold", {8'h0, outHour, outMinute, outSecond},
        32'h00070809);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    t5_on = 1'b0;
    chk("t5_cancel", 32'(editing), 0);
    chk("t5_no_write", 32'(wv_seen), 0);

    // T6: asynchronous reset in the middle of a repeat.
    start_edit(2'd3, 8'h05, 8'h10, 8'h20);
    inc = 1'b1;
    tick(8);
    #2 RST_N = 1'b0;
    #1;
    chk("t6_editing", 32'(editing), 0);
    chk("t6_hour", 32'(outHour), 0);
    chk("t6_slot", 32'(wr_slot), 0);
    inc = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick(1);

    // Random stimulus, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      edit_start = ($urandom_range(0, 19) == 0);
      slot_sel = 2'($urandom_range(0, 3));
      field_next = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) inc = ~inc;
      if ($urandom_range(0, 11) == 0) dec = ~dec;
      commit = ($urandom_range(0, 29) == 0);
      cancel = ($urandom_range(0, 49) == 0);
      wr_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      inHour = ($urandom_range(0, 3) == 0) ? 8'($urandom)
             : bcd($urandom_range(0, 23));
      inMinute = ($urandom_range(0, 3) == 0) ? 8'($urandom)
               : bcd($urandom_range(0, 59));
      inSecond = bcd($urandom_range(0, 59));
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
